// File: rtl/rename_unit_if.sv
// Decode-to-rename bundle: two decoded slots in, renamed physical indices,
// free-pool status and stall out.
interface rename_unit_if;
   logic [4:0]  rs1_1, rs2_1, rd_1;
   logic [31:0] imm_1;
   logic [6:0]  opcode_1;
   logic [4:0]  rs1_2, rs2_2, rd_2;
   logic [31:0] imm_2;
   logic [6:0]  opcode_2;
   logic [5:0]  newrs1_1, newrs2_1, newrd_1;
   logic [5:0]  newrs1_2, newrs2_2, newrd_2;
   logic        freepool [63:0];
   logic        stall;

   modport master (
      output rs1_1, rs2_1, rd_1, imm_1, opcode_1,
      output rs1_2, rs2_2, rd_2, imm_2, opcode_2,
      input  newrs1_1, newrs2_1, newrd_1, newrs1_2, newrs2_2, newrd_2,
      input  freepool, stall
   );

   modport slave (
      input  rs1_1, rs2_1, rd_1, imm_1, opcode_1,
      input  rs1_2, rs2_2, rd_2, imm_2, opcode_2,
      output newrs1_1, newrs2_1, newrd_1, newrs1_2, newrs2_2, newrd_2,
      output freepool, stall
   );
endinterface

// File: rtl/rename_unit.sv
// Two-wide register rename: RAT lookup, lowest-first free-pool allocation,
// intra-group bypass and all-or-nothing stall when the pool runs dry.
module rename_lane #(
   parameter int NUM_ARCH = 32,
   parameter int NUM_PHYS = 64,
   localparam int AW = $clog2(NUM_ARCH),
   localparam int PW = $clog2(NUM_PHYS)
) (
   input  logic [NUM_ARCH-1:0][PW-1:0] rat,
   input  logic [6:0]                  opcode,
   input  logic [AW-1:0]               rs1,
   input  logic [AW-1:0]               rs2,
   input  logic [AW-1:0]               rd,
   output logic                        alloc,
   output logic [PW-1:0]               map1,
   output logic [PW-1:0]               map2
);
   logic writes_rd;

   always_comb begin
      case (opcode)
         7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
         7'b0010111, 7'b1101111, 7'b1100111: writes_rd = 1'b1;
         default:                            writes_rd = 1'b0;
      endcase
   end

   assign alloc = writes_rd && (rd != '0);
   assign map1  = (rs1 == '0) ? '0 : rat[rs1];
   assign map2  = (rs2 == '0) ? '0 : rat[rs2];
endmodule

module rename_unit #(
   parameter int NUM_ARCH = 32,
   parameter int NUM_PHYS = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   rename_unit_if.slave  bus
);
   localparam int AW        = $clog2(NUM_ARCH);
   localparam int PW        = $clog2(NUM_PHYS);
   localparam int NUM_LANES = 2;

   logic [NUM_ARCH-1:0][PW-1:0]  rat_q;
   logic [NUM_PHYS-1:0]          free_q;

   logic [NUM_LANES-1:0][6:0]    lane_op;
   logic [NUM_LANES-1:0][AW-1:0] lane_rs1, lane_rs2, lane_rd;
   logic [NUM_LANES-1:0]         lane_alloc;
   logic [NUM_LANES-1:0][PW-1:0] lane_map1, lane_map2;

   logic [NUM_LANES-1:0][PW-1:0] nrs1_q, nrs2_q, nrd_q;
   logic                         stall_q;

   logic [PW-1:0] first, second, pd1, pd2, src1_2, src2_2;
   logic          found1, found2, stall_c, do1, do2;
   logic          unused_imm;

   assign lane_op[0]  = bus.opcode_1;
   assign lane_rs1[0] = bus.rs1_1;
   assign lane_rs2[0] = bus.rs2_1;
   assign lane_rd[0]  = bus.rd_1;
   assign lane_op[1]  = bus.opcode_2;
   assign lane_rs1[1] = bus.rs1_2;
   assign lane_rs2[1] = bus.rs2_2;
   assign lane_rd[1]  = bus.rd_2;
   assign unused_imm  = ^{bus.imm_1, bus.imm_2};

   rename_lane #(.NUM_ARCH(NUM_ARCH), .NUM_PHYS(NUM_PHYS)) u_lane [NUM_LANES-1:0] (
      .rat    (rat_q),
      .opcode (lane_op),
      .rs1    (lane_rs1),
      .rs2    (lane_rs2),
      .rd     (lane_rd),
      .alloc  (lane_alloc),
      .map1   (lane_map1),
      .map2   (lane_map2)
   );

   // Lowest and second-lowest free physical registers.
   always_comb begin
      first  = '0;
      second = '0;
      found1 = 1'b0;
      found2 = 1'b0;
      for (int i = 0; i < NUM_PHYS; i++) begin
         if (free_q[i]) begin
            if (!found1) begin
               first  = PW'(i);
               found1 = 1'b1;
            end else if (!found2) begin
               second = PW'(i);
               found2 = 1'b1;
            end
         end
      end
   end

   always_comb begin
      if (lane_alloc[0] && lane_alloc[1]) stall_c = !found2;
      else if (lane_alloc[0] || lane_alloc[1]) stall_c = !found1;
      else stall_c = 1'b0;
      do1 = lane_alloc[0] && !stall_c;
      do2 = lane_alloc[1] && !stall_c;
      pd1 = first;
      pd2 = lane_alloc[0] ? second : first;
      // Slot 2 must see slot 1's fresh destination, not the stale RAT entry.
      src1_2 = (do1 && bus.rs1_2 == bus.rd_1) ? pd1 : lane_map1[1];
      src2_2 = (do1 && bus.rs2_2 == bus.rd_1) ? pd1 : lane_map2[1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ARCH; i++) rat_q[i] <= PW'(i);
         free_q  <= {{(NUM_PHYS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
         nrs1_q  <= '0;
         nrs2_q  <= '0;
         nrd_q   <= '0;
         stall_q <= 1'b0;
      end else begin
         nrs1_q[0] <= lane_map1[0];
         nrs2_q[0] <= lane_map2[0];
         nrs1_q[1] <= src1_2;
         nrs2_q[1] <= src2_2;
         nrd_q[0]  <= do1 ? pd1 : '0;
         nrd_q[1]  <= do2 ? pd2 : '0;
         stall_q   <= stall_c;
         // Slot 2 is written last so it wins when both target the same rd.
         if (do1) begin
            rat_q[bus.rd_1] <= pd1;
            free_q[pd1]     <= 1'b0;
         end
         if (do2) begin
            rat_q[bus.rd_2] <= pd2;
            free_q[pd2]     <= 1'b0;
         end
      end
   end

   assign bus.newrs1_1 = nrs1_q[0];
   assign bus.newrs2_1 = nrs2_q[0];
   assign bus.newrd_1  = nrd_q[0];
   assign bus.newrs1_2 = nrs1_q[1];
   assign bus.newrs2_2 = nrs2_q[1];
   assign bus.newrd_2  = nrd_q[1];
   assign bus.stall    = stall_q;

   for (genvar g = 0; g < NUM_PHYS; g++) begin : g_fp
      assign bus.freepool[g] = free_q[g];
   end
endmodule

// File: tb/tb_rename_unit.sv
// Scoreboard bench for rename_unit: driver queues hand-computed expectations,
// monitor compares them one cycle after each issue.
module tb_rename_unit;
   localparam logic [63:0] RESET_FP = 64'hFFFF_FFFF_0000_0000;

   typedef struct {
      string       name;
      logic [5:0]  r11, r21, d1, r12, r22, d2;
      logic        st;
      logic [63:0] fp;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb [$];

   rename_unit_if bus ();

   rename_unit #(.NUM_ARCH(32), .NUM_PHYS(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic issue(input string nm, input logic rst,
                        input logic [6:0] o1, input logic [4:0] a1, b1, d1,
                        input logic [6:0] o2, input logic [4:0] a2, b2, d2,
                        input logic [5:0] e11, e21, ed1, e12, e22, ed2,
                        input logic est, input logic [63:0] efp);
      exp_t e;
      @(negedge clk);
      rst_n        = rst;
      bus.opcode_1 = o1;  bus.rs1_1 = a1;  bus.rs2_1 = b1;  bus.rd_1 = d1;
      bus.opcode_2 = o2;  bus.rs1_2 = a2;  bus.rs2_2 = b2;  bus.rd_2 = d2;
      bus.imm_1    = $urandom;
      bus.imm_2    = $urandom;
      e.name = nm;
      e.r11 = e11; e.r21 = e21; e.d1 = ed1;
      e.r12 = e12; e.r22 = e22; e.d2 = ed2;
      e.st = est;  e.fp = efp;
      sb.push_back(e);
   endtask

   task automatic do_reset(input string nm);
      issue(nm, 1'b0, 7'h33, 5'd1, 5'd2, 5'd3, 7'h33, 5'd4, 5'd5, 5'd6,
            6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, RESET_FP);
   endtask

   // Monitor: every issued group produces exactly one registered response.
   initial begin
      exp_t        e;
      logic [63:0] fp;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i < 64; i++) fp[i] = bus.freepool[i];
            chk({e.name, ".newrs1_1"}, 64'(bus.newrs1_1), 64'(e.r11));
            chk({e.name, ".newrs2_1"}, 64'(bus.newrs2_1), 64'(e.r21));
            chk({e.name, ".newrd_1"},  64'(bus.newrd_1),  64'(e.d1));
            chk({e.name, ".newrs1_2"}, 64'(bus.newrs1_2), 64'(e.r12));
            chk({e.name, ".newrs2_2"}, 64'(bus.newrs2_2), 64'(e.r22));
            chk({e.name, ".newrd_2"},  64'(bus.newrd_2),  64'(e.d2));
            chk({e.name, ".stall"},    64'(bus.stall),    64'(e.st));
            chk({e.name, ".freepool"}, fp,                e.fp);
         end
      end
   end

   initial begin
      logic [5:0]  r1, r2;
      logic [63:0] efp;
      int          wait_cyc;
      bus.opcode_1 = '0; bus.rs1_1 = '0; bus.rs2_1 = '0; bus.rd_1 = '0; bus.imm_1 = '0;
      bus.opcode_2 = '0; bus.rs1_2 = '0; bus.rs2_2 = '0; bus.rd_2 = '0; bus.imm_2 = '0;

      do_reset("reset0");
      // add x5,x1,x2 ; store with rs1=x5 (bypassed) and rs2=x6
      issue("add_store", 1'b1, 7'b0110011, 5'd1, 5'd2, 5'd5, 7'b0100011, 5'd5, 5'd6, 5'd9,
            6'd1, 6'd2, 6'd32, 6'd32, 6'd6, 6'd0, 1'b0, 64'hFFFF_FFFE_0000_0000);

      do_reset("reset1");
      // addi x3,x1 ; add x4,x3,x3
      issue("addi_add", 1'b1, 7'b0010011, 5'd1, 5'd0, 5'd3, 7'b0110011, 5'd3, 5'd3, 5'd4,
            6'd1, 6'd0, 6'd32, 6'd32, 6'd32, 6'd33, 1'b0, 64'hFFFF_FFFC_0000_0000);
      // branch x3,x4 ; add x0,x4,x5 -> no allocation, RAT reads only
      issue("rd0_read", 1'b1, 7'b1100011, 5'd3, 5'd4, 5'd0, 7'b0110011, 5'd4, 5'd5, 5'd0,
            6'd32, 6'd33, 6'd0, 6'd33, 6'd5, 6'd0, 1'b0, 64'hFFFF_FFFC_0000_0000);

      do_reset("reset2");
      // lui x7 ; jal x7 with rs1=x7 bypassed
      issue("waw_x7", 1'b1, 7'b0110111, 5'd0, 5'd0, 5'd7, 7'b1101111, 5'd7, 5'd0, 5'd7,
            6'd0, 6'd0, 6'd32, 6'd32, 6'd0, 6'd33, 1'b0, 64'hFFFF_FFFC_0000_0000);
      // load x8,(x7) ; jalr x0,x8 with rs2=x7
      issue("x7_reads33", 1'b1, 7'b0000011, 5'd7, 5'd0, 5'd8, 7'b1100111, 5'd8, 5'd7, 5'd0,
            6'd33, 6'd0, 6'd34, 6'd34, 6'd33, 6'd0, 1'b0, 64'hFFFF_FFF8_0000_0000);

      do_reset("reset3");
      // auipc x1 ; add x2,x1,x2 repeated until the pool is empty
      for (int c = 0; c < 16; c++) begin
         r1  = (c == 0) ? 6'd1 : 6'(30 + 2*c);
         r2  = (c == 0) ? 6'd2 : 6'(31 + 2*c);
         efp = RESET_FP & ~(((64'd1 << (2*c + 2)) - 64'd1) << 32);
         issue($sformatf("fill%0d", c), 1'b1, 7'b0010111, 5'd1, 5'd2, 5'd1,
               7'b0110011, 5'd1, 5'd2, 5'd2,
               r1, r2, 6'(32 + 2*c), 6'(32 + 2*c), r2, 6'(33 + 2*c), 1'b0, efp);
      end
      issue("stall_dual", 1'b1, 7'b0010111, 5'd1, 5'd2, 5'd1, 7'b0110011, 5'd1, 5'd2, 5'd2,
            6'd62, 6'd63, 6'd0, 6'd62, 6'd63, 6'd0, 1'b1, 64'h0);
      issue("stall_single", 1'b1, 7'b0100011, 5'd2, 5'd1, 5'd0, 7'b0010011, 5'd2, 5'd0, 5'd9,
            6'd63, 6'd62, 6'd0, 6'd63, 6'd0, 6'd0, 1'b1, 64'h0);

      do_reset("reset4");
      issue("post_reset_map", 1'b1, 7'b0100011, 5'd1, 5'd2, 5'd0, 7'b1100011, 5'd7, 5'd3, 5'd0,
            6'd1, 6'd2, 6'd0, 6'd7, 6'd3, 6'd0, 1'b0, RESET_FP);

      wait_cyc = 0;
      while (sb.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Register-rename stage of the two-wide out-of-order front end; sits between the two decode slots and issue.
- Each cycle it maps the architectural sources and destination of two decoded instructions (slot 1 older than slot 2) onto 64 physical registers.
- It uses a 32-entry register alias table (RAT) and a 64-entry free pool, and exposes the free pool as a status output.

Parameters:
- NUM_ARCH, 32, architectural registers (5-bit index).
- NUM_PHYS, 64, physical registers (6-bit index).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- rs1_1, rs2_1, rd_1  input  5 each  slot-1 architectural source 1, source 2 and destination.
- imm_1  input  32  slot-1 immediate; accepted, not used.
- opcode_1  input  7  slot-1 RISC-V opcode.
- rs1_2, rs2_2, rd_2, imm_2, opcode_2  input  5/5/5/32/7  slot-2 equivalents.
- newrs1_1, newrs2_1, newrd_1  output  6 each  slot-1 physical source 1, source 2 and destination.
- newrs1_2, newrs2_2, newrd_2  output  6 each  slot-2 physical source 1, source 2 and destination.
- freepool  output  1 x 64 (unpacked array [63:0])  1 = physical register free.
- stall  output  1  group could not be renamed this cycle.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - RAT[i]=i for i=0..31.
  - freepool[i]=0 for i<32, freepool[i]=1 for i>=32.
  - All new* outputs=0; stall=0.
  - Reset asserted mid-operation discards all mappings and restores these values.
- Writes-rd opcodes: 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111.
- A slot allocates only if its opcode is a writes-rd opcode AND rd!=0.
  - Non-allocating slot: newrd=0, no RAT or free-pool change.
  - Stores, branches and unknown opcodes never allocate.
- Source mapping uses the RAT contents before this cycle's update:
  - newrs1_k = RAT[rs1_k], newrs2_k = RAT[rs2_k], for every opcode.
  - Architectural x0 always maps to physical 0.
- Allocation order:
  - Slot 1 takes the lowest-indexed free register.
  - Slot 2 takes the next-lowest free register (the lowest if slot 1 does not allocate).
  - Allocated registers are cleared in freepool.
- Intra-group bypass: if slot 1 allocates and rs1_2 or rs2_2 equals rd_1, that slot-2 source gets slot 1's new physical register.
- RAT update: RAT[rd_1]=newrd_1, then RAT[rd_2]=newrd_2. If rd_1==rd_2, slot 2 wins.
- Insufficient free registers (fewer free than allocations required):
  - Whole group not renamed: stall=1, newrd_1=newrd_2=0, RAT and freepool unchanged.
  - Source outputs still show the current RAT mappings.
- Latency: all outputs are registered and reflect the inputs sampled at the previous rising edge (1 cycle).
- No reclaim port: freepool bits only clear, except on reset.

Test Plan:
- Reset → freepool[0..31]=0, freepool[32..63]=1, all new*=0, stall=0.
- After reset, slot1 add x5,x1,x2 (0110011), slot2 opcode 0100011 → newrs1_1=1, newrs2_1=2, newrd_1=32, newrd_2=0, freepool[32]=0.
- Slot1 addi x3,x1 (0010011); slot2 add x4,x3,x3 → newrd_1=32, newrd_2=33, newrs1_2=newrs2_2=32; next cycle a source x3 reads 32.
- Both slots write x7 → newrd_1=32, newrd_2=33; the following cycle an rs1=x7 yields 33.
- Slot rd=0 with opcode 0110011 → newrd=0, freepool unchanged.
- Issue 16 cycles of dual allocations (regs 32..63 consumed), then one more → stall=1, newrd_1=newrd_2=0; assert rst_n=0 → freepool restored to reset pattern.
